// File: rtl/ravenoc_pkg.sv
// Shared router types: flit/VC widths, flit-type encoding and the flit request bundle.
package ravenoc_pkg;

   localparam int unsigned FlitWidth  = 34;
   localparam int unsigned NumVirtChn = 3;
   localparam int unsigned VcWidth    = 2;

   typedef enum logic [1:0] {
      HeadFlit     = 2'b00,
      BodyFlit     = 2'b01,
      TailFlit     = 2'b10,
      HeadTailFlit = 2'b11
   } flit_type_t;

   typedef struct packed {
      logic                 valid;
      logic [VcWidth-1:0]   vc_id;
      logic [FlitWidth-1:0] flit;
   } s_flit_req_t;

endpackage

// File: rtl/output_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping to 0.
module output_rr_arbiter import ravenoc_pkg::*; #(
   parameter int unsigned N    = 4,
   parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [PtrW-1:0] ptr,
   output logic [N-1:0]    grant
);

   logic            found;
   logic [PtrW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PtrW'((32'(ptr) + i) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_module.sv
// Output stage of one router port: per-VC wormhole locks, fixed VC priority, per-VC round robin.
// Define OUTPUT_MODULE_SKID_EN to register the outgoing flit (1-cycle latency, ready path cut).
module output_module import ravenoc_pkg::*; #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned FLIT_WIDTH = FlitWidth,
   parameter int unsigned NUM_VC     = NumVirtChn,
   parameter int unsigned VC_WIDTH   = VcWidth
) (
   input  logic                                           clk,
   input  logic                                           arst,
   input  logic [NUM_PORTS*(FLIT_WIDTH+VC_WIDTH+1)-1:0]   fin_req_i,
   output logic [NUM_PORTS-1:0]                           fin_resp_o,
   output logic [FLIT_WIDTH+VC_WIDTH:0]                   fout_req_o,
   input  logic                                           fout_resp_i
);

   localparam int unsigned ReqW   = FLIT_WIDTH + VC_WIDTH + 1;
   localparam int unsigned PtrW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned VcIdxW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   logic [ReqW-1:0]      req      [NUM_PORTS];
   logic [NUM_PORTS-1:0] elig     [NUM_VC];
   logic [NUM_PORTS-1:0] rr_grant [NUM_VC];

   logic [NUM_VC-1:0] locked_q, locked_d;
   logic [PtrW-1:0]   owner_q  [NUM_VC];
   logic [PtrW-1:0]   owner_d  [NUM_VC];
   logic [PtrW-1:0]   rr_q     [NUM_VC];
   logic [PtrW-1:0]   rr_d     [NUM_VC];

   logic                 win_any;
   logic [VcIdxW-1:0]    win_vc;
   logic [NUM_PORTS-1:0] grant;
   logic [ReqW-1:0]      sel_req;
   logic [PtrW-1:0]      sel_port;
   logic [PtrW-1:0]      next_port;
   flit_type_t           sel_type;
   logic                 can_fire;
   logic                 fire;

   // Eligibility: the owner of a locked VC, or any head/head_tail on an idle VC.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         req[p] = fin_req_i[p*ReqW +: ReqW];
      end
      for (int v = 0; v < NUM_VC; v++) begin
         elig[v] = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (req[p][ReqW-1] && (req[p][FLIT_WIDTH +: VC_WIDTH] == VC_WIDTH'(v))) begin
               if (locked_q[v]) begin
                  elig[v][p] = (owner_q[v] == PtrW'(p));
               end else begin
                  elig[v][p] = (req[p][FLIT_WIDTH-1 -: 2] == HeadFlit) ||
                               (req[p][FLIT_WIDTH-1 -: 2] == HeadTailFlit);
               end
            end
         end
      end
   end

   for (genvar v = 0; v < NUM_VC; v++) begin : g_arb
      output_rr_arbiter #(
         .N    (NUM_PORTS),
         .PtrW (PtrW)
      ) u_arb (
         .req   (elig[v]),
         .ptr   (rr_q[v]),
         .grant (rr_grant[v])
      );
   end

   // Ascending scan so the highest-numbered eligible VC is the one left standing.
   always_comb begin
      win_any = 1'b0;
      win_vc  = '0;
      grant   = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (|elig[v]) begin
            win_any = 1'b1;
            win_vc  = VcIdxW'(v);
            grant   = locked_q[v] ? elig[v] : rr_grant[v];
         end
      end
   end

   always_comb begin
      sel_req  = '0;
      sel_port = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_req  = req[p];
            sel_port = PtrW'(p);
         end
      end
      sel_type  = flit_type_t'(sel_req[FLIT_WIDTH-1 -: 2]);
      next_port = (32'(sel_port) == NUM_PORTS - 1) ? '0 : sel_port + PtrW'(1);
   end

`ifdef OUTPUT_MODULE_SKID_EN
   logic [ReqW-1:0] skid_q;

   assign can_fire   = ~skid_q[ReqW-1] | fout_resp_i;
   assign fout_req_o = skid_q;

   always_ff @(posedge clk) begin
      if (arst) begin
         skid_q <= '0;
      end else if (can_fire) begin
         skid_q <= sel_req;
      end
   end
`else
   assign can_fire   = fout_resp_i;
   assign fout_req_o = arst ? '0 : sel_req;
`endif

   assign fire       = win_any & can_fire & ~arst;
   assign fin_resp_o = (can_fire && !arst) ? grant : '0;

   always_comb begin
      locked_d = locked_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      if (fire) begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (win_vc == VcIdxW'(v)) begin
               unique case (sel_type)
                  HeadFlit: begin
                     locked_d[v] = 1'b1;
                     owner_d[v]  = sel_port;
                     rr_d[v]     = next_port;
                  end
                  HeadTailFlit: rr_d[v]     = next_port;
                  TailFlit:     locked_d[v] = 1'b0;
                  BodyFlit:     ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         locked_q <= '0;
         for (int v = 0; v < NUM_VC; v++) begin
            owner_q[v] <= '0;
            rr_q[v]    <= '0;
         end
      end else begin
         locked_q <= locked_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
      end
   end

endmodule

// File: tb/tb_output_module.sv
// Self-checking bench for output_module: directed scenarios plus random packet traffic
// against a procedural per-VC lock/round-robin model.
module tb_output_module;
   import ravenoc_pkg::*;

   localparam int NP = 4;
   localparam int FW = FlitWidth;
   localparam int NV = NumVirtChn;
   localparam int VW = VcWidth;
   localparam int RW = FW + VW + 1;

   logic             clk = 1'b0;
   logic             arst;
   logic [NP*RW-1:0] fin_req;
   logic [NP-1:0]    fin_resp;
   logic [RW-1:0]    fout_req;
   logic             fout_resp;
   s_flit_req_t      req [NP];

   int tests = 0;
   int fails = 0;
   int transfers = 0;

   always #5 clk = ~clk;

   always_comb begin
      fin_req = '0;
      for (int p = 0; p < NP; p++) fin_req[p*RW +: RW] = req[p];
   end

   output_module #(
      .NUM_PORTS  (NP),
      .FLIT_WIDTH (FW),
      .NUM_VC     (NV),
      .VC_WIDTH   (VW)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .fin_req_i   (fin_req),
      .fin_resp_o  (fin_resp),
      .fout_req_o  (fout_req),
      .fout_resp_i (fout_resp)
   );

   // Reference model state
   bit          m_locked [NV];
   int          m_owner  [NV];
   int          m_rr     [NV];
   int          m_wp = -1;
   logic [NP-1:0] m_resp = '0;
   s_flit_req_t m_out = '0;
   s_flit_req_t m_reg = '0;

   function automatic s_flit_req_t mk(int vc, logic [1:0] ty, logic [31:0] d);
      s_flit_req_t r;
      r.valid = 1'b1;
      r.vc_id = VW'(vc);
      r.flit  = {ty, d};
      return r;
   endfunction

   // Compare process: evaluate the model from current inputs and check the DUT.
   always @(negedge clk) begin
      int  cand;
      bit  rdy;
      m_wp = -1;
      for (int v = NV - 1; v >= 0; v--) begin
         if (m_wp < 0) begin
            if (m_locked[v]) begin
               if (req[m_owner[v]].valid && int'(req[m_owner[v]].vc_id) == v) m_wp = m_owner[v];
            end else begin
               for (int k = 0; k < NP; k++) begin
                  cand = (m_rr[v] + k) % NP;
                  if (m_wp < 0 && req[cand].valid && int'(req[cand].vc_id) == v &&
                      (req[cand].flit[FW-1 -: 2] == 2'b00 || req[cand].flit[FW-1 -: 2] == 2'b11))
                     m_wp = cand;
               end
            end
         end
      end
`ifdef OUTPUT_MODULE_SKID_EN
      rdy   = !m_reg.valid || fout_resp;
      m_out = m_reg;
`else
      rdy   = fout_resp;
      m_out = (!arst && m_wp >= 0) ? req[m_wp] : '0;
`endif
      m_resp = '0;
      if (!arst && rdy && m_wp >= 0) m_resp[m_wp] = 1'b1;

      tests++;
      if (fin_resp !== m_resp) begin
         fails++;
         $display("FAIL model_resp @%0t: got %b want %b", $time, fin_resp, m_resp);
      end
      tests++;
      if (fout_req !== m_out) begin
         fails++;
         $display("FAIL model_out @%0t: got %h want %h", $time, fout_req, m_out);
      end
   end

   // Model state update on the clock edge, using the decision made at the preceding negedge.
   always @(posedge clk) begin
      s_flit_req_t r;
      int          v;
      if (arst) begin
         for (int i = 0; i < NV; i++) begin
            m_locked[i] = 1'b0;
            m_owner[i]  = 0;
            m_rr[i]     = 0;
         end
         m_reg = '0;
      end else begin
         if (m_resp != '0) begin
            transfers++;
            r = req[m_wp];
            v = int'(r.vc_id);
            case (r.flit[FW-1 -: 2])
               2'b00: begin
                  m_locked[v] = 1'b1;
                  m_owner[v]  = m_wp;
                  m_rr[v]     = (m_wp + 1) % NP;
               end
               2'b11:   m_rr[v] = (m_wp + 1) % NP;
               2'b10:   m_locked[v] = 1'b0;
               default: ;
            endcase
         end
`ifdef OUTPUT_MODULE_SKID_EN
         if (fout_resp || !m_reg.valid) m_reg = (m_resp != '0) ? req[m_wp] : '0;
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      for (int p = 0; p < NP; p++) req[p] = '0;
   endtask

   task automatic drive(int p, int vc, logic [1:0] ty, logic [31:0] d);
      req[p] = mk(vc, ty, d);
   endtask

   task automatic do_reset();
      arst = 1'b1;
      clear_all();
      tick();
      tick();
      arst = 1'b0;
   endtask

   // Hand-computed expectation for the current cycle, then advance one clock.
   task automatic cycle_chk(input string name, input logic [NP-1:0] er, input s_flit_req_t eo);
      @(negedge clk);
`ifndef OUTPUT_MODULE_SKID_EN
      tests++;
      if (fin_resp !== er) begin
         fails++;
         $display("FAIL %s resp: got %b want %b", name, fin_resp, er);
      end
      tests++;
      if (fout_req !== eo) begin
         fails++;
         $display("FAIL %s out: got %h want %h", name, fout_req, eo);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   // Random source state per port
   bit          s_act  [NP];
   bit          s_pres [NP];
   int          s_len  [NP];
   int          s_pos  [NP];
   int          s_vc   [NP];
   int          s_seq  [NP];

   initial begin
      logic [NP-1:0] acc;
      bit            rst_now;
      logic [1:0]    ty;

      arst      = 1'b1;
      fout_resp = 1'b1;
      clear_all();
      tick();

      // Reset gates outputs even with a live request
      drive(0, 0, 2'b00, 32'h1);
      cycle_chk("reset_gate0", 4'b0000, '0);
      cycle_chk("reset_gate1", 4'b0000, '0);
      arst = 1'b0;
      clear_all();

      // head_tail passes straight through, VC0 stays idle
      drive(0, 0, 2'b11, 32'h0000_0001);
      cycle_chk("t1_headtail", 4'b0001, mk(0, 2'b11, 32'h0000_0001));
      clear_all();
      drive(1, 0, 2'b00, 32'h11);
      cycle_chk("t1_vc0_idle", 4'b0010, mk(0, 2'b00, 32'h11));

      // Two heads on VC0: port1 owns the VC until its tail
      do_reset();
      drive(1, 0, 2'b00, 32'hA1);
      drive(2, 0, 2'b00, 32'hB1);
      cycle_chk("t2_head1", 4'b0010, mk(0, 2'b00, 32'hA1));
      drive(1, 0, 2'b01, 32'hA2);
      cycle_chk("t2_body1", 4'b0010, mk(0, 2'b01, 32'hA2));
      drive(1, 0, 2'b10, 32'hA3);
      cycle_chk("t2_tail1", 4'b0010, mk(0, 2'b10, 32'hA3));
      req[1] = '0;
      cycle_chk("t2_head2", 4'b0100, mk(0, 2'b00, 32'hB1));
      clear_all();

      // Round robin across all ports on VC1
      do_reset();
      for (int p = 0; p < NP; p++) drive(p, 1, 2'b11, 32'(p));
      for (int i = 0; i < 6; i++)
         cycle_chk("t3_rr", NP'(1 << (i % NP)), mk(1, 2'b11, 32'(i % NP)));
      clear_all();

      // Higher VC preempts a locked lower VC between flits
      do_reset();
      drive(0, 0, 2'b00, 32'hC1);
      cycle_chk("t4_head0", 4'b0001, mk(0, 2'b00, 32'hC1));
      drive(0, 0, 2'b01, 32'hC2);
      drive(3, 2, 2'b11, 32'hD1);
      cycle_chk("t4_vc2", 4'b1000, mk(2, 2'b11, 32'hD1));
      req[3] = '0;
      cycle_chk("t4_body0", 4'b0001, mk(0, 2'b01, 32'hC2));
      drive(0, 0, 2'b10, 32'hC3);
      cycle_chk("t4_tail0", 4'b0001, mk(0, 2'b10, 32'hC3));
      clear_all();

      // Backpressure holds state; lock taken on the accepting cycle
      do_reset();
      fout_resp = 1'b0;
      drive(1, 0, 2'b00, 32'hE1);
      for (int i = 0; i < 3; i++) cycle_chk("t5_stall", 4'b0000, mk(0, 2'b00, 32'hE1));
      fout_resp = 1'b1;
      cycle_chk("t5_go", 4'b0010, mk(0, 2'b00, 32'hE1));
      req[1] = '0;
      drive(2, 0, 2'b00, 32'hF1);
      cycle_chk("t5_locked", 4'b0000, '0);
      clear_all();

      // Reset mid-packet drops the lock; orphan body is ignored
      do_reset();
      drive(2, 0, 2'b00, 32'h61);
      cycle_chk("t6_head2", 4'b0100, mk(0, 2'b00, 32'h61));
      clear_all();
      arst = 1'b1;
      tick();
      arst = 1'b0;
      drive(2, 0, 2'b01, 32'h62);
      cycle_chk("t6_orphan", 4'b0000, '0);
      drive(1, 0, 2'b00, 32'h71);
      cycle_chk("t6_head1", 4'b0010, mk(0, 2'b00, 32'h71));
      drive(1, 0, 2'b01, 32'h72);
      cycle_chk("t6_body1", 4'b0010, mk(0, 2'b01, 32'h72));
      drive(1, 0, 2'b10, 32'h73);
      cycle_chk("t6_tail1", 4'b0010, mk(0, 2'b10, 32'h73));
      clear_all();

      // Random packet traffic
      do_reset();
      transfers = 0;
      for (int p = 0; p < NP; p++) begin
         s_act[p]  = 1'b0;
         s_pres[p] = 1'b0;
         s_seq[p]  = 0;
      end
      for (int c = 0; c < 4000; c++) begin
         arst      = ($urandom_range(0, 499) == 0);
         fout_resp = ($urandom_range(0, 9) < 7);
         for (int p = 0; p < NP; p++) begin
            if (!s_act[p] && $urandom_range(0, 2) == 0) begin
               s_act[p] = 1'b1;
               s_len[p] = $urandom_range(1, 4);
               s_pos[p] = 0;
               s_vc[p]  = $urandom_range(0, NV - 1);
            end
            if (s_act[p] && !s_pres[p] && $urandom_range(0, 3) != 0) s_pres[p] = 1'b1;
            if (s_pres[p]) begin
               if (s_len[p] == 1)                 ty = 2'b11;
               else if (s_pos[p] == 0)            ty = 2'b00;
               else if (s_pos[p] == s_len[p] - 1) ty = 2'b10;
               else                               ty = 2'b01;
               drive(p, s_vc[p], ty, {8'(p), 24'(s_seq[p])});
            end else begin
               req[p] = '0;
            end
         end
         @(posedge clk);
         acc     = m_resp;
         rst_now = arst;
         #1;
         for (int p = 0; p < NP; p++) begin
            if (rst_now) begin
               s_act[p]  = 1'b0;
               s_pres[p] = 1'b0;
            end else if (acc[p]) begin
               s_pres[p] = 1'b0;
               s_seq[p]++;
               s_pos[p]++;
               if (s_pos[p] == s_len[p]) s_act[p] = 1'b0;
            end
         end
      end
      arst = 1'b0;
      clear_all();
      tick();

      tests++;
      if (transfers < 500) begin
         fails++;
         $display("FAIL progress: got %0d transfers want >= 500", transfers);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/output_module.md
Name: output_module

Overview:
- Output side of one router port; the counterpart of the per-port input stage.
- Collects flit requests from the other input ports of the router that target this port.
- Arbitrates per virtual channel with wormhole locking: a packet owns its VC from head to tail.
- Drives the single outgoing flit link toward the neighbour router or NI, honouring its ready handshake.

Parameters:
- NUM_PORTS, 4, number of input ports that can request this output (5-port router minus self).
- FLIT_WIDTH, 34, flit payload width; bits [33:32] are the flit type.
- NUM_VC, 3, number of virtual channels.
- VC_WIDTH, 2, VC id width (MinBitWidth(NUM_VC-1)).

Ports:
- clk, input, 1: clock.
- arst, input, 1: reset. Synchronous, active-high.
- fin_req_i, input, NUM_PORTS*(FLIT_WIDTH+VC_WIDTH+1): per-port request {valid, vc_id, flit}. Port p occupies slice p; valid is the MSB of each slice.
- fin_resp_o, output, NUM_PORTS: per-port ready.
- fout_req_o, output, FLIT_WIDTH+VC_WIDTH+1: outgoing {valid, vc_id, flit}.
- fout_resp_i, input, 1: downstream ready.

Behaviour:
- Flit type encoding: 00 head, 01 body, 10 tail, 11 head_tail.
- Transfer rule: a transfer occurs when valid and ready are both 1 in the same cycle. A valid request must hold its data stable until it is accepted.
- Per-VC state machine: IDLE or LOCKED(owner port). Each VC also has a round-robin pointer rr[v].
- Eligibility of port p on VC v:
  - VC v LOCKED and owner == p: eligible.
  - VC v IDLE and flit type is head or head_tail: eligible.
  - Anything else (body/tail on an IDLE VC, or request on a VC locked to another port): not eligible. The port stalls with fin_resp_o[p] = 0.
- VC selection: the highest-numbered VC with at least one eligible request wins the cycle. Grant is fixed-priority by VC, combinational.
- Port selection within the winning VC:
  - LOCKED: the owner port.
  - IDLE: round-robin among eligible ports, searching from rr[v] upward with wrap-around at NUM_PORTS-1 to 0.
- Exactly one grant per cycle at most; grant is one-hot.
- Outputs:
  - fout_req_o = granted port's request, or all-zero when there is no grant.
  - fin_resp_o[p] = grant[p] & fout_resp_i.
  - Combinational path, zero-cycle latency.
- State updates on transfer only:
  - head: VC goes IDLE -> LOCKED(p) and rr[v] <= p+1 mod NUM_PORTS.
  - head_tail: VC stays IDLE, rr[v] <= p+1.
  - body: no state change.
  - tail: LOCKED -> IDLE.
- No transfer (fout_resp_i = 0): all state holds and outputs remain a stable function of the inputs.
- Multiple VCs may be LOCKED to different ports at once; their flits interleave on the output flit-by-flit.
- Reset: all VCs IDLE, rr[v] = 0, fout_req_o = 0, fin_resp_o = 0.
- Reset asserted mid-packet: locks are dropped. A subsequent orphan body/tail flit is ineligible, and the next head is arbitrated normally.

Optional Feature:
- Macro: OUTPUT_MODULE_SKID_EN.
- Defined:
  - Adds a 1-entry output register; fout_req_o is driven from the register (1-cycle latency).
  - The arbiter may fire when the register is empty or draining this cycle: fin_resp_o[p] = grant[p] & (~reg_valid | fout_resp_i). This breaks the ready path from downstream to upstream.
  - Lock and rr updates occur on the input-side transfer.
  - Register clears on reset.
- Undefined: combinational pass-through as described in Behaviour.

Decomposition:
- Shared package ravenoc_pkg holds: FlitWidth, NumVirtChn, VcWidth, the flit-type enum (head/body/tail/head_tail), and the request struct {valid, vc_id, flit}.
- Sub-module output_rr_arbiter (parameter N): inputs req[N], ptr; output one-hot grant. Instantiated once per VC.

Test Plan:
- Port0 head_tail on VC0, flit data 0x3_0000_0001, fout_resp_i = 1 -> same cycle: fout_req_o valid with identical payload and vc 0, fin_resp_o = 4'b0001; VC0 remains IDLE.
- Ports 1 and 2 both send a head on VC0 with rr = 0 -> port1 wins. Its head/body/tail go out on cycles 0-2 while port2 sees fin_resp_o[2] = 0. Port2's head goes out on cycle 3.
- Ports 0-3 each stream head_tail flits on VC1 continuously -> grant order 0,1,2,3,0,1.
- Port0 is LOCKED on VC0 mid-packet and port3 presents a head on VC2 -> VC2 is granted first. Port0's body is accepted the next cycle once VC2's packet is a head_tail.
- fout_resp_i held at 0 for 3 cycles with port1 requesting a head on VC0 -> fout_req_o stable, fin_resp_o = 0, VC0 stays IDLE. When ready rises, the transfer occurs and VC0 locks to port1.
- arst pulsed while VC0 is locked to port2, then port2 presents a body -> not granted. Port1's head is then granted and locks VC0.
